// File: rtl/conv_kxk_pipe.sv
// KxK sliding-window convolution: column-shift window, registered products,
// pipelined binary adder tree, then bias / optional ReLU / saturation.
module conv_kxk_pipe #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned K         = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         row_start,
  input  logic [BIT_WIDTH*K-1:0]       in_col,
  input  logic [BIT_WIDTH*K*K-1:0]     filter,
  input  logic [OUT_WIDTH-1:0]         bias,
  input  logic                         relu_en,
  output logic                         out_valid,
  output logic [OUT_WIDTH-1:0]         conv_out
);

  localparam int unsigned N      = K * K;
  localparam int unsigned PROD_W = 2 * BIT_WIDTH;
  localparam int unsigned TREE_D = $clog2(N);
  localparam int unsigned ACC_W  = PROD_W + TREE_D;
  localparam int unsigned LAT    = 2 + TREE_D;
  localparam int unsigned CNT_W  = $clog2(K + 1);
  localparam int unsigned SUM_W  = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

  logic signed [BIT_WIDTH-1:0] win_q [K][K];
  logic [CNT_W-1:0]            col_cnt_q;
  logic [CNT_W-1:0]            col_cnt_d;
  logic [LAT-1:0]              vld_q;
  logic signed [PROD_W-1:0]    prod_q [N];
  logic signed [ACC_W-1:0]     lvl    [TREE_D+1][N+1];
  logic signed [ACC_W-1:0]     sum_d  [TREE_D][N];
  logic signed [ACC_W-1:0]     sum_q  [TREE_D][N];
  logic signed [SUM_W-1:0]     s_d;
  logic signed [SUM_W-1:0]     res_d;

  // Window: columns shift toward 0, newest column enters at K-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_q[r][c] <= '0;
    end else if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= in_col[BIT_WIDTH*r +: BIT_WIDTH];
      end
    end
  end

  always_comb begin
    col_cnt_d = col_cnt_q;
    if (in_valid) begin
      if (row_start)
        col_cnt_d = CNT_W'(1);
      else if (col_cnt_q < CNT_W'(K))
        col_cnt_d = col_cnt_q + CNT_W'(1);
    end
  end

  // Valid tag travels alongside the data, one bit per pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
      vld_q     <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      vld_q     <= {vld_q[LAT-2:0], in_valid && (col_cnt_d == CNT_W'(K))};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        prod_q[i] <= '0;
    end else begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod_q[K*r+c] <= PROD_W'(win_q[r][c]) *
                           PROD_W'($signed(filter[BIT_WIDTH*(K*r+c) +: BIT_WIDTH]));
    end
  end

  // Tree levels; slot N is a zero pad so an odd node adds zero (passes through).
  for (genvar i = 0; i < N; i++) begin : g_lvl0
    assign lvl[0][i] = ACC_W'(prod_q[i]);
  end
  for (genvar l = 0; l < TREE_D; l++) begin : g_lvl
    for (genvar i = 0; i < N; i++) begin : g_node
      assign lvl[l+1][i] = sum_q[l][i];
    end
  end
  for (genvar l = 0; l <= TREE_D; l++) begin : g_pad
    assign lvl[l][N] = '0;
  end

  always_comb begin
    for (int l = 0; l < TREE_D; l++)
      for (int i = 0; i < N; i++)
        sum_d[l][i] = '0;
    for (int l = 0; l < TREE_D; l++)
      for (int i = 0; i < (N + 1) / 2; i++)
        sum_d[l][i] = lvl[l][2*i] + lvl[l][2*i+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < TREE_D; l++)
        for (int i = 0; i < N; i++)
          sum_q[l][i] <= '0;
    end else begin
      for (int l = 0; l < TREE_D; l++)
        for (int i = 0; i < N; i++)
          sum_q[l][i] <= sum_d[l][i];
    end
  end

  // Output stage: bias, optional ReLU, saturation to OUT_WIDTH.
  always_comb begin
    s_d   = SUM_W'(lvl[TREE_D][0]) + SUM_W'($signed(bias));
    res_d = s_d;
    if (relu_en && s_d[SUM_W-1])
      res_d = '0;
    else if (s_d > MAX_V)
      res_d = MAX_V;
    else if (s_d < MIN_V)
      res_d = MIN_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      conv_out  <= '0;
    end else begin
      out_valid <= vld_q[LAT-1];
      if (vld_q[LAT-1])
        conv_out <= OUT_WIDTH'(res_d);
    end
  end

endmodule

// File: tb/tb_conv_kxk_pipe.sv
// Self-checking bench for conv_kxk_pipe: 32-bit and 16-bit output instances
// driven in parallel, checked every cycle against a row-history model.
module tb_conv_kxk_pipe;

  localparam int K    = 5;
  localparam int BW   = 8;
  localparam int N    = K * K;
  localparam int COLW = BW * K;
  localparam int FW   = BW * N;
  localparam int LAT  = 2 + $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            row_start;
  logic [COLW-1:0] in_col;
  logic [FW-1:0]   filter;
  logic [31:0]     bias;
  logic [15:0]     bias16;
  logic            relu_en;
  logic            ov32, ov16;
  logic [31:0]     co32;
  logic [15:0]     co16;

  assign bias16 = bias[15:0];

  always #5 clk = ~clk;

  conv_kxk_pipe #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .K(K)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .row_start(row_start),
    .in_col(in_col), .filter(filter), .bias(bias), .relu_en(relu_en),
    .out_valid(ov32), .conv_out(co32));

  conv_kxk_pipe #(.BIT_WIDTH(BW), .OUT_WIDTH(16), .K(K)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .row_start(row_start),
    .in_col(in_col), .filter(filter), .bias(bias16), .relu_en(relu_en),
    .out_valid(ov16), .conv_out(co16));

  typedef struct {
    int     due;
    longint raw;
  } exp_t;

  typedef struct {
    int     w;
    int     x;
    int     b;
    logic   relu;
    longint e32;
    longint e16;
  } vec_t;

  int              n_pass = 0;
  int              n_total = 0;
  int              cyc = 0;
  exp_t            exp_q[$];
  logic [COLW-1:0] hist[$];
  longint          last32 = 0;
  longint          last16 = 0;
  longint          got32[$];
  longint          got16[$];
  int              gotc[$];
  vec_t            vt[8];
  longint          saved;
  int              b5;
  logic [COLW-1:0] cols[8];

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  function automatic longint post(input longint raw, input longint b, input logic relu, input int w);
    longint s;
    s = raw + b;
    if (relu && s < 0) s = 0;
    return sat(s, w);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Dot product of the last K columns of the current row with the filter.
  function automatic longint window_sum();
    longint acc;
    logic [COLW-1:0] colv;
    logic signed [BW-1:0] px, wt;
    acc = 0;
    for (int c = 0; c < K; c++) begin
      colv = hist[c];
      for (int r = 0; r < K; r++) begin
        px = colv[BW*r +: BW];
        wt = filter[BW*(K*r+c) +: BW];
        acc += longint'(px) * longint'(wt);
      end
    end
    return acc;
  endfunction

  task automatic model_beat(input logic rs, input logic [COLW-1:0] col);
    exp_t e;
    if (rs) hist.delete();
    hist.push_back(col);
    if (hist.size() > K) void'(hist.pop_front());
    if (hist.size() == K) begin
      e.due = cyc + LAT;
      e.raw = window_sum();
      exp_q.push_back(e);
    end
  endtask

  task automatic check_out();
    logic ev;
    exp_t e;
    ev = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev = 1'b1;
      e = exp_q.pop_front();
      last32 = post(e.raw, longint'($signed(bias)), relu_en, 32);
      last16 = post(e.raw, longint'($signed(bias16)), relu_en, 16);
    end
    chk("out_valid32", longint'(ov32), longint'(ev));
    chk("out_valid16", longint'(ov16), longint'(ev));
    chk("conv_out32", longint'($signed(co32)), last32);
    chk("conv_out16", longint'($signed(co16)), last16);
    if (ov32) begin
      got32.push_back(longint'($signed(co32)));
      got16.push_back(longint'($signed(co16)));
      gotc.push_back(cyc);
    end
  endtask

  task automatic cycle(input logic iv, input logic rs, input logic [COLW-1:0] col);
    in_valid  = iv;
    row_start = rs;
    in_col    = col;
    @(posedge clk);
    cyc++;
    if (iv) model_beat(rs, col);
    #1;
    check_out();
  endtask

  function automatic logic [COLW-1:0] rand_col();
    logic [COLW-1:0] v;
    for (int r = 0; r < K; r++) v[BW*r +: BW] = BW'($urandom);
    return v;
  endfunction

  function automatic logic [COLW-1:0] col_all(input int x);
    logic [COLW-1:0] v;
    for (int r = 0; r < K; r++) v[BW*r +: BW] = BW'(x);
    return v;
  endfunction

  function automatic logic [FW-1:0] fill_filter(input int w);
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[BW*i +: BW] = BW'(w);
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_filter();
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[BW*i +: BW] = BW'($urandom);
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, rand_col());
  endtask

  task automatic clear_got();
    got32.delete();
    got16.delete();
    gotc.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    row_start = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    hist.delete();
    last32 = 0;
    last16 = 0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("rst_out_valid32", longint'(ov32), 0);
    chk("rst_conv_out32", longint'(co32), 0);
    chk("rst_out_valid16", longint'(ov16), 0);
    chk("rst_conv_out16", longint'(co16), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{w: 1,    x: 1,    b: 0,     relu: 1'b0, e32: 25,      e16: 25};
    vt[1] = '{w: -128, x: -128, b: 0,     relu: 1'b0, e32: 409600,  e16: 32767};
    vt[2] = '{w: 1,    x: -1,   b: 5,     relu: 1'b1, e32: 0,       e16: 0};
    vt[3] = '{w: 1,    x: -1,   b: 5,     relu: 1'b0, e32: -20,     e16: -20};
    vt[4] = '{w: 127,  x: -128, b: 0,     relu: 1'b0, e32: -406400, e16: -32768};
    vt[5] = '{w: 127,  x: 127,  b: -1000, relu: 1'b1, e32: 402225,  e16: 32767};
    vt[6] = '{w: -3,   x: 7,    b: 100,   relu: 1'b0, e32: -425,    e16: -425};
    vt[7] = '{w: -1,   x: 100,  b: -200,  relu: 1'b1, e32: 0,       e16: 0};

    rst_n = 1'b0; in_valid = 1'b0; row_start = 1'b0; in_col = '0;
    filter = '0; bias = '0; relu_en = 1'b0;
    do_reset();

    // Uniform-window vectors: five columns of one value, one result expected.
    for (int i = 0; i < 8; i++) begin
      filter = fill_filter(vt[i].w);
      bias = 32'(vt[i].b);
      relu_en = vt[i].relu;
      clear_got();
      cycle(1'b1, 1'b1, col_all(vt[i].x));
      repeat (4) cycle(1'b1, 1'b0, col_all(vt[i].x));
      idle(LAT + 2);
      chk($sformatf("tbl%0d_count", i), got32.size(), 1);
      chk($sformatf("tbl%0d_v32", i), (got32.size() > 0) ? got32[0] : -1, vt[i].e32);
      chk($sformatf("tbl%0d_v16", i), (got16.size() > 0) ? got16[0] : -1, vt[i].e16);
    end

    // Latency 7 after the completing beat, then a sixth beat one cycle later.
    filter = fill_filter(1); bias = '0; relu_en = 1'b0;
    clear_got();
    cycle(1'b1, 1'b1, col_all(1));
    repeat (4) cycle(1'b1, 1'b0, col_all(1));
    b5 = cyc;
    cycle(1'b1, 1'b0, col_all(1));
    idle(LAT + 2);
    chk("lat_count", got32.size(), 2);
    chk("lat_first", (gotc.size() > 0) ? gotc[0] - b5 : -1, 7);
    chk("lat_second", (gotc.size() > 1) ? gotc[1] - gotc[0] : -1, 1);
    chk("lat_val2", (got32.size() > 1) ? got32[1] : -1, 25);

    // One-hot tap(2,0) selects row 2 of the oldest column.
    filter = '0;
    filter[BW*(K*2+0) +: BW] = 8'd1;
    clear_got();
    for (int c = 1; c <= K; c++) begin
      logic [COLW-1:0] v;
      for (int r = 0; r < K; r++) v[BW*r +: BW] = BW'(10 * c + r);
      cycle(1'b1, (c == 1), v);
    end
    idle(LAT + 2);
    chk("onehot_val", (got32.size() > 0) ? got32[0] : -1, 12);

    // Row restart on beat 4 of 8, back-to-back then gapped.
    filter = rand_filter(); bias = 32'd17; relu_en = 1'b0;
    for (int i = 0; i < 8; i++) cols[i] = rand_col();
    clear_got();
    for (int i = 0; i < 8; i++) cycle(1'b1, (i == 0 || i == 3), cols[i]);
    idle(LAT + 2);
    chk("rowstart_b2b_count", got32.size(), 1);
    saved = (got32.size() > 0) ? got32[0] : -1;
    clear_got();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, (i == 0 || i == 3), cols[i]);
      idle(2);
    end
    idle(LAT + 2);
    chk("rowstart_gap_count", got32.size(), 1);
    chk("rowstart_gap_val", (got32.size() > 0) ? got32[0] : -1, saved);

    // Reset kills an in-flight window; five fresh columns needed afterwards.
    filter = fill_filter(1); bias = '0;
    clear_got();
    cycle(1'b1, 1'b1, col_all(1));
    repeat (4) cycle(1'b1, 1'b0, col_all(1));
    idle(3);
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, col_all(1));
    idle(LAT + 2);
    chk("rst_midstream_count", got32.size(), 0);
    cycle(1'b1, 1'b0, col_all(1));
    idle(LAT + 2);
    chk("rst_after_count", got32.size(), 1);
    chk("rst_after_val", (got32.size() > 0) ? got32[0] : -1, 25);

    // Random streams: sparse valid, occasional row restarts, varying bias/relu.
    for (int seg = 0; seg < 4; seg++) begin
      filter = rand_filter();
      for (int t = 0; t < 150; t++) begin
        relu_en = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) bias = $urandom;
        else bias = 32'(int'($urandom_range(0, 4000)) - 2000);
        cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), rand_col());
      end
      idle(LAT + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
